// File: rtl/tone_sequencer.sv
// +--------------------------------------------------------------------------+
// | tone_sequencer: picks the note (manual keys or stored melody) for the     |
// | square-wave tone generator.  Rev 1.0                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tone_sequencer #(
  parameter int HALF_HZ    = 25_000_000,
  parameter int D0         = 1,
  parameter int D1         = 9,
  parameter int D2         = 7,
  parameter int NOTE_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw1_n,
  input  logic        sw2_n,
  input  logic        sw3_n,
  input  logic        play_n,
  output logic [23:0] half_period,
  output logic        tone_en,
  output logic        busy,
  output logic [1:0]  note_idx
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MANUAL    = 2'd1,
    PLAY_NOTE = 2'd2,
    PLAY_GAP  = 2'd3
  } state_t;

  localparam logic [23:0] HP_1 = 24'(HALF_HZ / 262);
  localparam logic [23:0] HP_7 = 24'(HALF_HZ / 494);
  localparam logic [23:0] HP_9 = 24'(HALF_HZ / 587);

  localparam logic [25:0] NOTE_LAST = 26'(NOTE_TICKS - 1);
  localparam logic [25:0] GAP_LAST  = 26'(GAP_TICKS - 1);

  // Digits without a table entry are rests.
  function automatic logic [23:0] digit_hp(input int digit);
    case (digit)
      1:       digit_hp = HP_1;
      7:       digit_hp = HP_7;
      9:       digit_hp = HP_9;
      default: digit_hp = 24'd0;
    endcase
  endfunction

  localparam logic [23:0] HP_D0 = digit_hp(D0);
  localparam logic [23:0] HP_D1 = digit_hp(D1);
  localparam logic [23:0] HP_D2 = digit_hp(D2);

  function automatic logic [23:0] slot_hp(input logic [1:0] slot);
    case (slot)
      2'd0:    slot_hp = HP_D0;
      2'd1:    slot_hp = HP_D1;
      default: slot_hp = HP_D2;
    endcase
  endfunction

  // Bit order {play, sw3, sw2, sw1}; all idle high.
  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic        play_prev;
  state_t      state;
  state_t      state_nx;
  logic [25:0] cnt;
  logic [25:0] cnt_nx;
  logic [1:0]  idx_nx;
  logic [23:0] hp_nx;
  logic        busy_nx;
  logic        play_start;
  logic        any_key;
  logic [23:0] manual_hp;

  assign play_start = play_prev & ~sync2[3];
  assign any_key    = ~&sync2[2:0];

  always_comb begin
    manual_hp = 24'd0;
    if (!sync2[0])      manual_hp = HP_D0;
    else if (!sync2[1]) manual_hp = HP_D1;
    else if (!sync2[2]) manual_hp = HP_D2;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = note_idx;
    hp_nx    = half_period;
    busy_nx  = busy;
    case (state)
      IDLE, MANUAL: begin
        if (play_start) begin
          state_nx = PLAY_NOTE;
          cnt_nx   = 26'd0;
          idx_nx   = 2'd0;
          hp_nx    = HP_D0;
          busy_nx  = 1'b1;
        end else begin
          state_nx = any_key ? MANUAL : IDLE;
          cnt_nx   = 26'd0;
          idx_nx   = 2'd0;
          hp_nx    = manual_hp;
          busy_nx  = 1'b0;
        end
      end
      PLAY_NOTE: begin
        hp_nx = slot_hp(note_idx);
        if (cnt == NOTE_LAST) begin
          state_nx = PLAY_GAP;
          cnt_nx   = 26'd0;
          hp_nx    = 24'd0;
        end else begin
          cnt_nx = cnt + 26'd1;
        end
      end
      PLAY_GAP: begin
        hp_nx = 24'd0;
        if (cnt == GAP_LAST) begin
          cnt_nx = 26'd0;
          if (note_idx < 2'd2) begin
            // The next slot's pitch is loaded on the same edge it begins.
            state_nx = PLAY_NOTE;
            idx_nx   = note_idx + 2'd1;
            hp_nx    = slot_hp(note_idx + 2'd1);
          end else begin
            state_nx = IDLE;
            idx_nx   = 2'd0;
            busy_nx  = 1'b0;
          end
        end else begin
          cnt_nx = cnt + 26'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 26'd0;
        idx_nx   = 2'd0;
        hp_nx    = 24'd0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= 4'hF;
      sync2       <= 4'hF;
      play_prev   <= 1'b1;
      state       <= IDLE;
      cnt         <= 26'd0;
      note_idx    <= 2'd0;
      half_period <= 24'd0;
      tone_en     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sync1       <= {play_n, sw3_n, sw2_n, sw1_n};
      sync2       <= sync1;
      play_prev   <= sync2[3];
      state       <= state_nx;
      cnt         <= cnt_nx;
      note_idx    <= idx_nx;
      half_period <= hp_nx;
      tone_en     <= (hp_nx != 24'd0);
      busy        <= busy_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer; a second instance has D1 overridden to a rest digit.
`default_nettype none

module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw1_n, sw2_n, sw3_n, play_n;
  logic [23:0] hp_a, hp_b;
  logic        en_a, en_b, busy_a, busy_b;
  logic [1:0]  idx_a, idx_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.NOTE_TICKS(10), .GAP_TICKS(4)) dut_a (
    .clk(clk), .rst(rst), .sw1_n(sw1_n), .sw2_n(sw2_n), .sw3_n(sw3_n),
    .play_n(play_n), .half_period(hp_a), .tone_en(en_a), .busy(busy_a),
    .note_idx(idx_a)
  );

  tone_sequencer #(.D1(5), .NOTE_TICKS(10), .GAP_TICKS(4)) dut_b (
    .clk(clk), .rst(rst), .sw1_n(sw1_n), .sw2_n(sw2_n), .sw3_n(sw3_n),
    .play_n(play_n), .half_period(hp_b), .tone_en(en_b), .busy(busy_b),
    .note_idx(idx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hand table: slot pitches for the default melody 1-9-7 and for the 1-5-7 variant.
  function automatic logic [23:0] exp_hp(input int slot, input bit alt);
    case (slot)
      0:       exp_hp = 24'd95419;
      1:       exp_hp = alt ? 24'd0 : 24'd42589;
      default: exp_hp = 24'd50607;
    endcase
  endfunction

  // Starts the melody and checks all 42 busy cycles.  poke: hold sw3 and
  // pulse play mid-melody; hold_play: keep play_n low past the end.
  task automatic play_and_check(input bit poke, input bit hold_play);
    int slot, pos;
    play_n = 1'b0;
    tick(2);
    check("pre_busy", busy_a, 0);
    tick(1);
    if (!hold_play) play_n = 1'b1;
    for (int i = 0; i < 42; i++) begin
      slot = i / 14;
      pos  = i % 14;
      if (poke && i == 5)  sw3_n  = 1'b0;
      if (poke && i == 20) play_n = 1'b0;
      if (poke && i == 23) play_n = 1'b1;
      check("mel_hp_a",   hp_a,   exp_hp(slot, 1'b0) & {24{pos < 10}});
      check("mel_en_a",   en_a,   pos < 10);
      check("mel_busy_a", busy_a, 1);
      check("mel_idx_a",  idx_a,  slot);
      check("mel_hp_b",   hp_b,   exp_hp(slot, 1'b1) & {24{pos < 10}});
      check("mel_en_b",   en_b,   (pos < 10) && (slot != 1));
      check("mel_busy_b", busy_b, 1);
      tick(1);
    end
    check("end_busy", busy_a, 0);
    check("end_hp",   hp_a,   0);
    check("end_idx",  idx_a,  0);
    if (poke) begin
      tick(1);
      check("held_sw3_hp", hp_a,   24'd50607);
      check("held_sw3_en", en_a,   1);
      check("held_busy",   busy_a, 0);
      sw3_n = 1'b1;
      tick(3);
      check("rel_sw3_hp", hp_a, 0);
    end
    if (hold_play) begin
      tick(6);
      check("no_retrig_busy", busy_a, 0);
      check("no_retrig_hp",   hp_a,   0);
      play_n = 1'b1;
      tick(3);
      check("no_retrig_busy2", busy_a, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    sw1_n = 1'b1; sw2_n = 1'b1; sw3_n = 1'b1; play_n = 1'b1;
    tick(2);
    check("rst_hp",   hp_a,   0);
    check("rst_en",   en_a,   0);
    check("rst_busy", busy_a, 0);
    check("rst_idx",  idx_a,  0);
    rst = 1'b0;
    tick(2);
    check("idle_hp", hp_a, 0);

    // Manual keys: 3-edge latency and priority.
    sw2_n = 1'b0;
    tick(2);
    check("sw2_early", hp_a, 0);
    tick(1);
    check("sw2_hp",   hp_a, 24'd42589);
    check("sw2_en",   en_a, 1);
    check("sw2_rest", hp_b, 0);
    check("sw2_rest_en", en_b, 0);
    sw1_n = 1'b0;
    tick(3);
    check("sw1_prio", hp_a, 24'd95419);
    sw1_n = 1'b1; sw2_n = 1'b1;
    tick(2);
    check("rel_early", hp_a, 24'd95419);
    tick(1);
    check("rel_hp", hp_a, 0);
    check("rel_en", en_a, 0);
    sw3_n = 1'b0;
    tick(3);
    check("sw3_hp", hp_a, 24'd50607);
    sw3_n = 1'b1;
    tick(3);

    play_and_check(1'b0, 1'b0);
    play_and_check(1'b1, 1'b0);
    play_and_check(1'b0, 1'b1);

    // Asynchronous reset during slot 1.
    play_n = 1'b0;
    tick(3);
    play_n = 1'b1;
    tick(16);
    check("pre_rst_idx", idx_a, 1);
    check("pre_rst_hp",  hp_a,  24'd42589);
    #3 rst = 1'b1;
    #1;
    check("arst_hp",   hp_a,   0);
    check("arst_en",   en_a,   0);
    check("arst_busy", busy_a, 0);
    check("arst_idx",  idx_a,  0);
    tick(1);
    rst = 1'b0;
    tick(3);
    check("post_rst_busy", busy_a, 0);
    play_and_check(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
